neo_multichannel: RTL and testbench

Time-multiplexed, multi-channel Nonlinear Energy Operator with threshold spike detection. It replaces the single-channel NEO with a block parametrised in sample width, output width and channel count. It accepts channel-interleaved samples and emits psi[n] = x[n]^2 - x[n-1]*x[n+1] per channel through a 2-stage pipeline, plus a per-channel spike flag with optional refractory lockout. It sits between the sample front-end and the spike sorter.

---
 rtl/neo_multichannel.sv | 200 ++++++++++++++++++++
 tb/tb_neo_multichannel.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/neo_multichannel.sv
// Time-multiplexed multi-channel Nonlinear Energy Operator with threshold spike flag.
// Optional refractory lockout is enabled by defining NEO_REFRACT_EN.
module neo_multichannel #(
    parameter int N       = 16,
    parameter int M       = 32,
    parameter int C       = 4,
    parameter int REFRACT = 8,
    parameter int CW      = (C > 1) ? $clog2(C) : 1
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [CW-1:0]        in_ch,
    input  logic signed [N-1:0]  in_data,
    input  logic signed [M-1:0]  threshold,
    output logic                 out_valid,
    output logic [CW-1:0]        out_ch,
    output logic signed [M-1:0]  out_psi,
    output logic                 out_spike
);

    localparam int P = 2 * N + 1;

    logic signed [N-1:0]   h1_q [C];
    logic signed [N-1:0]   h1_d [C];
    logic signed [N-1:0]   h2_q [C];
    logic signed [N-1:0]   h2_d [C];
    logic [1:0]            fill_q [C];
    logic [1:0]            fill_d [C];

    logic                  accept;
    logic signed [N-1:0]   h1_cur;
    logic signed [N-1:0]   h2_cur;
    logic [1:0]            fill_cur;
    logic signed [2*N-1:0] h1_x, h2_x, x_x;

    logic signed [2*N-1:0] sq_q, sq_d, pr_q, pr_d;
    logic                  v1_q, v1_d;
    logic [CW-1:0]         ch1_q, ch1_d;

    logic signed [P-1:0]   diff;
    logic signed [M-1:0]   psi_sat;
    logic                  above;
    logic                  spike;

    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         out_ch_q, out_ch_d;
    logic signed [M-1:0]   out_psi_q, out_psi_d;
    logic                  out_spike_q, out_spike_d;

    // When C fills the index space every channel code is legal.
    generate
        if (C == (1 << CW)) begin : g_all_ch
            assign accept = in_valid;
        end else begin : g_some_ch
            assign accept = in_valid && (in_ch < CW'(C));
        end
    endgenerate

    always_comb begin
        h1_cur   = '0;
        h2_cur   = '0;
        fill_cur = '0;
        for (int c = 0; c < C; c++) begin
            if (in_ch == CW'(c)) begin
                h1_cur   = h1_q[c];
                h2_cur   = h2_q[c];
                fill_cur = fill_q[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < C; c++) begin
            h1_d[c]   = h1_q[c];
            h2_d[c]   = h2_q[c];
            fill_d[c] = fill_q[c];
            if (accept && (in_ch == CW'(c))) begin
                h2_d[c]   = h1_q[c];
                h1_d[c]   = in_data;
                fill_d[c] = (fill_q[c] == 2'd2) ? 2'd2 : fill_q[c] + 2'd1;
            end
        end
    end

    assign h1_x = {{N{h1_cur[N-1]}}, h1_cur};
    assign h2_x = {{N{h2_cur[N-1]}}, h2_cur};
    assign x_x  = {{N{in_data[N-1]}}, in_data};

    always_comb begin
        sq_d  = h1_x * h1_x;
        pr_d  = x_x * h2_x;
        v1_d  = accept && (fill_cur == 2'd2);
        ch1_d = in_ch;
    end

    // Difference of two 2N-bit products is exact at 2N+1 bits.
    assign diff = {sq_q[2*N-1], sq_q} - {pr_q[2*N-1], pr_q};

    generate
        if (M >= P) begin : g_extend
            assign psi_sat = M'(diff);
        end else begin : g_saturate
            logic [P-M:0] top;
            assign top     = diff[P-1:M-1];
            assign psi_sat = ((&top) || !(|top)) ? diff[M-1:0]
                           : (diff[P-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}});
        end
    endgenerate

    assign above = psi_sat > threshold;

`ifdef NEO_REFRACT_EN
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic [RW-1:0] rc_q [C];
    logic [RW-1:0] rc_d [C];
    logic [RW-1:0] rc_cur;

    always_comb begin
        rc_cur = '0;
        for (int c = 0; c < C; c++) begin
            if (ch1_q == CW'(c)) rc_cur = rc_q[c];
        end
    end

    assign spike = v1_q && above && (rc_cur == '0);

    always_comb begin
        for (int c = 0; c < C; c++) begin
            rc_d[c] = rc_q[c];
            if (v1_q && (ch1_q == CW'(c))) begin
                if (spike)                rc_d[c] = RW'(REFRACT);
                else if (rc_q[c] != '0)   rc_d[c] = rc_q[c] - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < C; c++) rc_q[c] <= '0;
        end else begin
            for (int c = 0; c < C; c++) rc_q[c] <= rc_d[c];
        end
    end
`else
    assign spike = v1_q && above;
`endif

    // Result fields hold between valid outputs.
    always_comb begin
        out_valid_d = v1_q;
        out_ch_d    = out_ch_q;
        out_psi_d   = out_psi_q;
        out_spike_d = out_spike_q;
        if (v1_q) begin
            out_ch_d    = ch1_q;
            out_psi_d   = psi_sat;
            out_spike_d = spike;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < C; c++) begin
                h1_q[c]   <= '0;
                h2_q[c]   <= '0;
                fill_q[c] <= '0;
            end
            sq_q        <= '0;
            pr_q        <= '0;
            v1_q        <= 1'b0;
            ch1_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_psi_q   <= '0;
            out_spike_q <= 1'b0;
        end else begin
            for (int c = 0; c < C; c++) begin
                h1_q[c]   <= h1_d[c];
                h2_q[c]   <= h2_d[c];
                fill_q[c] <= fill_d[c];
            end
            sq_q        <= sq_d;
            pr_q        <= pr_d;
            v1_q        <= v1_d;
            ch1_q       <= ch1_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_psi_q   <= out_psi_d;
            out_spike_q <= out_spike_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_psi   = out_psi_q;
    assign out_spike = out_spike_q;

endmodule

// File: tb/tb_neo_multichannel.sv
// Directed bench for neo_multichannel: a 32-bit and a 24-bit output instance share stimulus.
module tb_neo_multichannel;

    logic               Clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [2:0]         in_ch;
    logic signed [15:0] in_data;
    logic signed [31:0] thr32;
    logic signed [23:0] thr24;

    logic               v32, v24, sp32, sp24;
    logic [2:0]         ch32, ch24;
    logic signed [31:0] psi32;
    logic signed [23:0] psi24;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    neo_multichannel #(.N(16), .M(32), .C(5), .REFRACT(8)) dut32 (
        .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .threshold(thr32), .out_valid(v32), .out_ch(ch32), .out_psi(psi32), .out_spike(sp32)
    );

    neo_multichannel #(.N(16), .M(24), .C(5), .REFRACT(8)) dut24 (
        .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .threshold(thr24), .out_valid(v24), .out_ch(ch24), .out_psi(psi24), .out_spike(sp24)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] ch;
        int         d;
        logic       ev;
        logic [2:0] ech;
        longint     epsi;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] ch, input int d);
        @(posedge Clk);
        #1;
        in_valid = v;
        in_ch    = ch;
        in_data  = d[15:0];
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge Clk);
        #1;
        reset    = 1'b0;
    endtask

    task automatic feed3(input string nm, input int a, input int b, input int c, input longint thr,
                         input longint e32, input longint e24, input logic esp);
        do_reset();
        thr32 = thr[31:0];
        thr24 = (thr > 64'sd8388607) ? 24'sh7fffff : thr[23:0];
        drive(1'b1, 3'd0, a);
        drive(1'b1, 3'd0, b);
        drive(1'b1, 3'd0, c);
        drive(1'b0, 3'd0, 0);
        @(negedge Clk);
        chk({nm, " early valid"}, longint'(v32), 0);
        drive(1'b0, 3'd0, 0);
        @(negedge Clk);
        chk({nm, " valid32"}, longint'(v32), 1);
        chk({nm, " ch32"}, longint'(ch32), 0);
        chk({nm, " psi32"}, longint'(psi32), e32);
        chk({nm, " spike32"}, longint'(sp32), longint'(esp));
        chk({nm, " valid24"}, longint'(v24), 1);
        chk({nm, " psi24"}, longint'(psi24), e24);
    endtask

    initial begin
        int  idx;
        logic exp_sp;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_ch    = '0;
        in_data  = '0;
        thr32    = 32'sd1000;
        thr24    = 24'sd1000;
        #3;
        chk("reset out_valid", longint'(v32), 0);
        chk("reset out_psi", longint'(psi32), 0);
        chk("reset out_ch", longint'(ch32), 0);
        chk("reset out_spike", longint'(sp32), 0);

        // Each row's expectation is what the outputs show in the cycle that row is driven.
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 0,  1'b0, 3'd0, 0};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 3,  1'b0, 3'd0, 0};
        tbl[2]  = '{1'b0, 1'b1, 3'd0, 5,  1'b0, 3'd0, 0};
        tbl[3]  = '{1'b0, 1'b1, 3'd0, 2,  1'b0, 3'd0, 0};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 0,  1'b0, 3'd0, 0};
        tbl[5]  = '{1'b0, 1'b0, 3'd0, 0,  1'b1, 3'd0, 19};
        tbl[6]  = '{1'b1, 1'b0, 3'd0, 0,  1'b0, 3'd0, 0};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 1,  1'b0, 3'd0, 0};
        tbl[8]  = '{1'b0, 1'b1, 3'd1, 10, 1'b0, 3'd0, 0};
        tbl[9]  = '{1'b0, 1'b1, 3'd0, 2,  1'b0, 3'd0, 0};
        tbl[10] = '{1'b0, 1'b1, 3'd5, -7, 1'b0, 3'd0, 0};
        tbl[11] = '{1'b0, 1'b1, 3'd1, 10, 1'b0, 3'd0, 0};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 3,  1'b0, 3'd0, 0};
        tbl[13] = '{1'b0, 1'b1, 3'd1, 10, 1'b0, 3'd0, 0};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 0,  1'b1, 3'd0, 1};
        tbl[15] = '{1'b0, 1'b0, 3'd0, 0,  1'b1, 3'd1, 0};
        tbl[16] = '{1'b0, 1'b0, 3'd0, 0,  1'b0, 3'd0, 0};

        for (int i = 0; i < 17; i++) begin
            @(posedge Clk);
            #1;
            reset    = tbl[i].rst;
            in_valid = tbl[i].v;
            in_ch    = tbl[i].ch;
            in_data  = tbl[i].d[15:0];
            @(negedge Clk);
            chk($sformatf("vec%0d valid", i), longint'(v32), longint'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d ch", i), longint'(ch32), longint'(tbl[i].ech));
                chk($sformatf("vec%0d psi", i), longint'(psi32), tbl[i].epsi);
                chk($sformatf("vec%0d spike", i), longint'(sp32), 0);
            end
        end

        // Reset mid-clock while one result is on the outputs and another is in stage 1.
        do_reset();
        drive(1'b1, 3'd0, 1);
        drive(1'b1, 3'd0, 2);
        drive(1'b1, 3'd0, 3);
        drive(1'b1, 3'd0, 4);
        drive(1'b0, 3'd0, 0);
        @(negedge Clk);
        chk("pre-reset valid", longint'(v32), 1);
        chk("pre-reset psi", longint'(psi32), 1);
        reset = 1'b1;
        #1;
        chk("midreset valid", longint'(v32), 0);
        chk("midreset psi", longint'(psi32), 0);
        chk("midreset psi24", longint'(psi24), 0);
        chk("midreset ch", longint'(ch32), 0);
        chk("midreset spike", longint'(sp32), 0);
        @(posedge Clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 3'd0, 1);
        drive(1'b1, 3'd0, 2);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                @(negedge Clk);
            end else begin
                drive(1'b0, 3'd0, 0);
                @(negedge Clk);
            end
            chk($sformatf("post-reset idle%0d valid", i), longint'(v32), 0);
        end

        feed3("ext_pos", 32767, -32768, -32768, 64'sd2147483647, 2147450880, 8388607, 1'b0);
        feed3("ext_mix", -32768, 32767, 32767, 64'sd2147483647, 2147385345, 8388607, 1'b0);
        feed3("ext_neg", 32767, 0, 32767, 64'sd2147483647, -1073676289, -8388608, 1'b0);
        feed3("thr_eq", 0, 10, 0, 64'sd100, 100, 100, 1'b0);
        feed3("thr_below", 0, 10, 0, 64'sd99, 100, 100, 1'b1);

        // Alternating 0/20 stream: psi alternates +400/-400 against threshold 100.
        do_reset();
        thr32 = 32'sd100;
        thr24 = 24'sd100;
        idx   = 0;
        for (int i = 0; i < 26; i++) begin
            if (i < 24) drive(1'b1, 3'd0, (i % 2 == 1) ? 20 : 0);
            else        drive(1'b0, 3'd0, 0);
            @(negedge Clk);
            if (v32) begin
                idx++;
`ifdef NEO_REFRACT_EN
                exp_sp = (idx == 1) || (idx == 11) || (idx == 21);
`else
                exp_sp = (idx % 2 == 1);
`endif
                chk($sformatf("spk out%0d psi", idx), longint'(psi32), (idx % 2 == 1) ? 400 : -400);
                chk($sformatf("spk out%0d spike", idx), longint'(sp32), longint'(exp_sp));
            end
        end
        chk("spk output count", longint'(idx), 22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
